// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the sign-magnitude adder
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int SIGN_BIT      = DEFAULT_WIDTH - 1;
  localparam logic [DEFAULT_WIDTH-2:0] MAX_MAG = {(DEFAULT_WIDTH-1){1'b1}};

endpackage

// File: rtl/adder_sm_add_core.sv
// rtl/adder_sm_add_core.sv - combinational sign-magnitude add with saturation
module sm_add_core
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int MW = WIDTH - 1;

  logic          sign_a;
  logic          sign_b;
  logic [MW-1:0] mag_a;
  logic [MW-1:0] mag_b;
  logic [MW:0]   mag_sum;
  logic [MW-1:0] mag_res;
  logic          sign_res;

  assign sign_a  = a[MW];
  assign sign_b  = b[MW];
  assign mag_a   = a[MW-1:0];
  assign mag_b   = b[MW-1:0];
  assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

  always_comb begin
    mag_res  = '0;
    sign_res = 1'b0;
    ovf      = 1'b0;
    if (sign_a == sign_b) begin
      sign_res = sign_a;
      if (mag_sum[MW]) begin
        mag_res = {MW{1'b1}};
        ovf     = 1'b1;
      end else begin
        mag_res = mag_sum[MW-1:0];
      end
    end else if (mag_a >= mag_b) begin
      mag_res  = mag_a - mag_b;
      sign_res = sign_a;
    end else begin
      mag_res  = mag_b - mag_a;
      sign_res = sign_b;
    end
    // A zero magnitude is always reported as +0, never -0.
    if (mag_res == '0) begin
      sign_res = 1'b0;
    end
  end

  assign sum = {sign_res, mag_res};

endmodule

// File: rtl/adder.sv
// rtl/adder.sv - registered sign-magnitude adder, one-cycle latency
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;

  logic [WIDTH-1:0] out_d, out_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  sm_add_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .b   (b),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // Result registers only load on a valid pair and hold otherwise.
  always_comb begin
    out_d   = out_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d = sum;
      ovf_d = sum_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - self-checking bench for adder
module tb_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         out_valid;
  logic         ovf;

  int errors;
  int checks;

  adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: convert to integers, add, clamp, convert back.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int maxm;
    int vx;
    int vy;
    int s;
    logic o;
    logic [W-1:0] r;
    maxm = (1 << (W - 1)) - 1;
    vx = x[W-1] ? -int'(x[W-2:0]) : int'(x[W-2:0]);
    vy = y[W-1] ? -int'(y[W-2:0]) : int'(y[W-2:0]);
    s  = vx + vy;
    o  = 1'b0;
    if (s > maxm) begin s = maxm; o = 1'b1; end
    if (s < -maxm) begin s = -maxm; o = 1'b1; end
    if (s < 0) r = {1'b1, 7'(-s)};
    else       r = {1'b0, 7'(s)};
    return {o, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out=%h out_valid=%b ovf=%b required 00/0/0", out, out_valid, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[8];
    logic [W-1:0] vb[8];
    logic [W-1:0] vo[8];
    logic         vf[8];
    va[0] = 8'b0011_0011; vb[0] = 8'b0100_1011; vo[0] = 8'b0111_1110; vf[0] = 1'b0;
    va[1] = 8'b1011_0101; vb[1] = 8'b1010_1010; vo[1] = 8'b1101_1111; vf[1] = 1'b0;
    va[2] = 8'b1000_0001; vb[2] = 8'b0000_1010; vo[2] = 8'b0000_1001; vf[2] = 1'b0;
    va[3] = 8'b1000_1011; vb[3] = 8'b0000_0101; vo[3] = 8'b1000_0110; vf[3] = 1'b0;
    va[4] = 8'b0111_1111; vb[4] = 8'b0000_0001; vo[4] = 8'b0111_1111; vf[4] = 1'b1;
    va[5] = 8'b1111_1111; vb[5] = 8'b1000_0001; vo[5] = 8'b1111_1111; vf[5] = 1'b1;
    va[6] = 8'b1000_0101; vb[6] = 8'b0000_0101; vo[6] = 8'b0000_0000; vf[6] = 1'b0;
    va[7] = 8'b1000_0000; vb[7] = 8'b1000_0000; vo[7] = 8'b0000_0000; vf[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out !== vo[i] || ovf !== vf[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed_%0d out=%b ovf=%b out_valid=%b required %b/%b/1",
                 i, out, ovf, out_valid, vo[i], vf[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [W:0] e;
    @(negedge clk);
    a = 8'b0000_0111; b = 8'b1000_0010; in_valid = 1'b1;
    e = model(a, b);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      checks++;
      if (out !== e[W-1:0] || ovf !== e[W] || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d out=%h ovf=%b out_valid=%b required %h/%b/0",
                 i, out, ovf, out_valid, e[W-1:0], e[W]);
      end
    end
  endtask

  task automatic test_stream(input string name, input int n, input int valid_pct);
    logic [W:0] held;
    logic [W:0] nxt;
    logic       exp_v;
    held  = {ovf, out};
    exp_v = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out !== held[W-1:0] || ovf !== held[W] || out_valid !== exp_v) begin
          errors++;
          $display("FAIL %s_%0d out=%h ovf=%b out_valid=%b required %h/%b/%b",
                   name, i, out, ovf, out_valid, held[W-1:0], held[W], exp_v);
        end
      end
      case ($urandom_range(0, 3))
        0: begin a = {1'b0, 7'($urandom_range(100, 127))}; b = {1'b0, 7'($urandom_range(0, 127))}; end
        1: begin a = {1'b1, 7'($urandom_range(100, 127))}; b = {1'b1, 7'($urandom_range(0, 127))}; end
        2: begin a = W'($urandom); b = {~a[W-1], a[W-2:0]}; end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
      in_valid = ($urandom_range(0, 99) < valid_pct);
      nxt   = model(a, b);
      if (in_valid) held = nxt;
      exp_v = in_valid;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out !== held[W-1:0] || ovf !== held[W] || out_valid !== exp_v) begin
      errors++;
      $display("FAIL %s_last out=%h ovf=%b out_valid=%b required %h/%b/%b",
               name, out, ovf, out_valid, held[W-1:0], held[W], exp_v);
    end
  endtask

  task automatic test_async_reset();
    logic [W:0] e;
    @(negedge clk);
    a = 8'b0111_0000; b = 8'b0010_0000; in_valid = 1'b1;
    @(negedge clk);
    a = 8'b0000_0011; b = 8'b0000_0100;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset out=%h out_valid=%b ovf=%b required 00/0/0", out, out_valid, ovf);
    end
    @(negedge clk);
    checks++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard out=%h out_valid=%b required 00/0", out, out_valid);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle out=%h out_valid=%b required 00/0", out, out_valid);
    end
    a = 8'b1000_0100; b = 8'b1000_0101; in_valid = 1'b1;
    e = model(a, b);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out !== e[W-1:0] || ovf !== e[W] || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first out=%h ovf=%b out_valid=%b required %h/%b/1",
               out, ovf, out_valid, e[W-1:0], e[W]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_hold();
    test_stream("random", 200, 50);
    test_stream("back_to_back", 60, 100);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
